// File: rtl/dffram_pkg.sv
// Shared types and helpers for the parametrised flip-flop RAM.
package dffram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int MAX_WIDTH = 256;
    localparam int MAX_BYTES = MAX_WIDTH / 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    // Callers zero-extend to MAX_WIDTH and truncate the result back to their word width.
    function automatic logic [MAX_WIDTH-1:0] byte_merge(
        input logic [MAX_WIDTH-1:0] old_w,
        input logic [MAX_WIDTH-1:0] new_w,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_WIDTH-1:0] res;
        res = old_w;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dffram_clear_ctrl.sv
// Clear engine: walks a pointer over every word after reset or on request.
//   state    | meaning
//   ST_IDLE  | normal port access, CLR sampled
//   ST_CLEAR | one word zeroed per edge, ports ignored
module dffram_clear_ctrl
    import dffram_pkg::*;
#(
    parameter int WORDS = 8,
    parameter int AW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    output logic          busy_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o
);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == AW'(WORDS - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o     = (state_q == ST_CLEAR);
    assign clr_we_o   = (state_q == ST_CLEAR);
    assign clr_addr_o = ptr_q;

endmodule

// File: rtl/dffram_param.sv
// Parametrised DFF RAM: one read/write byte-enabled port, one read-only port,
// optional same-cycle write forwarding to port 1, and a self-clearing array.
module dffram_param
    import dffram_pkg::*;
#(
    parameter  int WORDS  = 8,
    parameter  int WIDTH  = 32,
    parameter  int BYPASS = 1,
    localparam int AW     = clog2(WORDS)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CLR,
    output logic               BUSY,
    input  logic               EN0,
    input  logic [WIDTH/8-1:0] WE0,
    input  logic [AW-1:0]      A0,
    input  logic [WIDTH-1:0]   Di0,
    output logic [WIDTH-1:0]   Do0,
    input  logic               EN1,
    input  logic [AW-1:0]      A1,
    output logic [WIDTH-1:0]   Do1
);

    logic [WIDTH-1:0] mem_q [WORDS];
    logic             busy;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic [WIDTH-1:0] wr_word;
    logic [WIDTH-1:0] rd1_word;
    logic [WIDTH-1:0] do0_q, do0_d;
    logic [WIDTH-1:0] do1_q, do1_d;

    dffram_clear_ctrl #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_clear_ctrl (
        .clk_i      (CLK),
        .rst_n_i    (RST_N),
        .clr_i      (CLR),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign wr_word = WIDTH'(byte_merge(MAX_WIDTH'(mem_q[A0]), MAX_WIDTH'(Di0), MAX_BYTES'(WE0)));

    // Array is deliberately unreset; the clear engine zeroes it after reset instead.
    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (EN0 && (|WE0)) begin
            mem_q[A0] <= wr_word;
        end
    end

    always_comb begin
        rd1_word = mem_q[A1];
        if ((BYPASS != 0) && EN0 && (A0 == A1)) begin
            rd1_word = WIDTH'(byte_merge(MAX_WIDTH'(mem_q[A1]), MAX_WIDTH'(Di0), MAX_BYTES'(WE0)));
        end
    end

    always_comb begin
        do0_d = '0;
        do1_d = '0;
        if (!busy && EN0) do0_d = mem_q[A0];
        if (!busy && EN1) do1_d = rd1_word;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            do0_q <= '0;
            do1_q <= '0;
        end else begin
            do0_q <= do0_d;
            do1_q <= do1_d;
        end
    end

    assign Do0  = do0_q;
    assign Do1  = do1_q;
    assign BUSY = busy;

endmodule
